// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: feeds bytes from a TX FIFO to an external spi_master one
// transfer at a time and collects the received bytes into an RX FIFO.
// Optional completion watchdog: define SPI_SEQ_TIMEOUT_EN to build it in.

// Synchronous FIFO, power-of-two depth, combinational head read.
module spi_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; wraps naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

module spi_byte_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_recv,
  input  logic                  data_recv_vld,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_KICK  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  spi_start_q;
  logic                  vld_q;
  logic                  vld_rise;
  logic                  wdog_expire;
  logic                  tx_pop, rx_push;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] tx_head;

  spi_seq_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(sys_clk), .rst(rst),
    .push(tx_valid), .wdata(tx_data), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  spi_seq_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst(rst),
    .push(rx_push), .wdata(data_recv), .pop(rx_ready),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign spi_start = spi_start_q;
  assign data_in   = data_in_q;
  assign busy      = (state_q != S_IDLE);

  // Completion is a fresh low-to-high edge only; a level left high from the
  // previous transfer must not end the current one.
  assign vld_rise = data_recv_vld && !vld_q;

  // Next-state logic. The TX pop happens on the edge that enters LOAD so that
  // data_in already holds the byte for the whole spi_start pulse.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          state_d = S_LOAD;
          tx_pop  = 1'b1;
        end
      end
      S_LOAD: state_d = S_KICK;
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (vld_rise)         state_d = S_STORE;
        else if (wdog_expire) state_d = S_GAP;
      end
      S_STORE: begin
        // Hold here without losing the byte until the RX FIFO has room.
        if (!rx_full) begin
          rx_push = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!tx_empty) begin
            state_d = S_LOAD;
            tx_pop  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, start strobe, outgoing byte and completion-level history.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      spi_start_q <= 1'b0;
      data_in_q   <= '0;
      vld_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_start_q <= (state_d == S_LOAD);
      vld_q       <= data_recv_vld;
      if (tx_pop) data_in_q <= tx_head;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wdog_q, wdog_d;
  logic          err_q;

  // Counter is zero on the first WAIT cycle, so expiry lands on WAIT cycle
  // TIMEOUT_CYCLES; a completion in that same cycle still wins.
  assign wdog_expire = (state_q == S_WAIT) && !vld_rise &&
                       (wdog_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  // Watchdog count runs only while waiting for completion.
  always_comb begin
    wdog_d = '0;
    if (state_q == S_WAIT) wdog_d = wdog_q + 1'b1;
  end

  // Watchdog register and sticky error, cleared only by reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (wdog_expire) err_q <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/spi_byte_sequencer.md
SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of every byte word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16: entries per TX and RX FIFO, power of 2, at least 2.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2: idle sys_clk cycles between consecutive transfers, range 1..255.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: completion watchdog limit in sys_clk cycles.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port tx_data, input, DATA_WIDTH bits: byte to transmit.
REQ-008 The block SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-009 The block SHALL have port tx_ready, output, 1 bit: the TX FIFO is not full; a push occurs when tx_valid and tx_ready are both high.
REQ-010 The block SHALL have port rx_data, output, DATA_WIDTH bits: the received byte at the RX FIFO head.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: the RX FIFO is not empty.
REQ-012 The block SHALL have port rx_ready, input, 1 bit: a pop occurs when rx_valid and rx_ready are both high.
REQ-013 The block SHALL have port spi_start, output, 1 bit: start strobe to spi_master; spi_master starts a transfer on its falling edge.
REQ-014 The block SHALL have port data_in, output, DATA_WIDTH bits: the byte presented to spi_master.
REQ-015 The block SHALL have port data_recv, input, DATA_WIDTH bits: the byte received by spi_master.
REQ-016 The block SHALL have port data_recv_vld, input, 1 bit: spi_master completion level; it goes low at spi_master START and high at spi_master END.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-018 The block SHALL have port err_timeout, output, 1 bit: sticky watchdog error flag.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, KICK, WAIT, STORE and GAP, all registered.
REQ-020 IDLE SHALL go to LOAD when the TX FIFO is not empty, and SHALL stay in IDLE otherwise.
REQ-021 In LOAD, the block SHALL pop the TX FIFO head into the data_in register and drive spi_start=1 for exactly one cycle, then go to KICK.
REQ-022 KICK SHALL drive spi_start=0, creating the falling edge, then go to WAIT; data_in SHALL stay stable from LOAD until the next LOAD.
REQ-023 WAIT SHALL detect a rising edge of data_recv_vld, using a registered copy of data_recv_vld, then go to STORE; a level that is already high SHALL NOT count as completion.
REQ-024 STORE SHALL push data_recv into the RX FIFO and go to GAP; if the RX FIFO is full, STORE SHALL hold with no push and no data loss until space frees.
REQ-025 GAP SHALL count GAP_CYCLES cycles and then go to LOAD if the TX FIFO is not empty, otherwise to IDLE.
REQ-026 Each FIFO SHALL accept a simultaneous push and pop in one cycle when it is neither full nor empty: the level is unchanged and data order is preserved.
REQ-027 A push to a full FIFO and a pop from an empty FIFO SHALL be ignored, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 tx_ready and rx_valid SHALL be combinational from the FIFO full and empty flags, and rx_data SHALL show the head entry with zero-cycle read latency.
REQ-029 Latency SHALL be exactly 2 cycles from the TX FIFO becoming non-empty in IDLE to the spi_start falling edge, and 1 cycle from the data_recv_vld rising edge to the RX push when the RX FIFO is not full.

Reset
REQ-030 While rst=1, the block SHALL hold FSM=IDLE, both FIFOs empty, spi_start=0, data_in=0, busy=0, err_timeout=0, rx_valid=0 and tx_ready=1.
REQ-031 A reset asserted mid-transfer SHALL discard all FIFO contents and the in-flight byte, and SHALL produce no spurious spi_start falling edge after release.

Configuration
REQ-032 Macro SPI_SEQ_TIMEOUT_EN SHALL select the completion watchdog.
REQ-033 With SPI_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES with no completion, the block SHALL set err_timeout, skip the RX push and go to GAP.
REQ-034 With SPI_SEQ_TIMEOUT_EN defined, err_timeout SHALL be cleared only by rst.
REQ-035 With SPI_SEQ_TIMEOUT_EN undefined, the block SHALL have no watchdog counter, WAIT SHALL wait indefinitely, and err_timeout SHALL be tied to 0.

Verification
REQ-036 The bench SHALL push 0xA5 with spi_master plus a MISO loopback, and SHALL see spi_start high for 1 cycle, data_in=0xA5, then rx_data=0xA5 with rx_valid=1.
REQ-037 The bench SHALL push 0x01, 0x02 and 0x03 back-to-back, and SHALL see 3 transfers in order with exactly GAP_CYCLES=2 idle cycles between them and RX order 0x01, 0x02, 0x03.
REQ-038 The bench SHALL fill the TX FIFO with 16 pushes while transfers are stalled, and SHALL see tx_ready=0; a 17th push SHALL be ignored.
REQ-039 The bench SHALL hold rx_ready=0 and send 17 bytes, and SHALL see the FSM hold in STORE on byte 17; after one pop, byte 17 SHALL be stored with no loss.
REQ-040 The bench SHALL tie data_recv_vld=0 with TIMEOUT_CYCLES=16 and the macro defined, and SHALL see err_timeout=1 at cycle 16 of WAIT and the FSM back in IDLE.
REQ-041 The bench SHALL assert rst during WAIT, and SHALL see busy=0, rx_valid=0 and tx_ready=1 immediately, with no spi_start falling edge after release.
